// File: rtl/eth_parser_pkg.sv
// Shared L2 metadata types and constants for the Ethernet parse/build datapath.
package eth_parser_pkg;

  localparam logic [15:0] ETH_TPID_VLAN    = 16'h8100;
  localparam logic [4:0]  ETH_HDR_LEN_BASE = 5'd14;
  localparam logic [4:0]  ETH_HDR_LEN_VLAN = 5'd18;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic [4:0]  l2_header_len;
  } eth_metadata_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_hdr_state_t;

  function automatic logic [4:0] hdr_len(input logic vlan_present);
    return vlan_present ? ETH_HDR_LEN_VLAN : ETH_HDR_LEN_BASE;
  endfunction

endpackage

// File: rtl/eth_header_builder_if.sv
// Metadata-in / header-byte-out handshake bundle of the TX header builder.
interface eth_header_builder_if
  import eth_parser_pkg::*;
  ;
  eth_metadata_t meta_in;
  logic          meta_valid;
  logic          meta_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_sof;
  logic          tx_eof;
  logic          hdr_done;
  logic          len_mismatch;

  modport master (
    output meta_in, meta_valid, tx_ready,
    input  meta_ready, tx_data, tx_valid, tx_sof, tx_eof, hdr_done, len_mismatch
  );

  modport slave (
    input  meta_in, meta_valid, tx_ready,
    output meta_ready, tx_data, tx_valid, tx_sof, tx_eof, hdr_done, len_mismatch
  );
endinterface

// File: rtl/eth_hdr_byte_sel.sv
// Combinational map from header byte index to the network-order header byte.
module eth_hdr_byte_sel
  import eth_parser_pkg::*;
#(
  parameter logic [2:0] VLAN_PCP = 3'd0,
  parameter logic       VLAN_DEI = 1'b0
) (
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic        vlan_present,
  input  logic [11:0] vlan_id,
  input  logic [4:0]  idx,
  output logic [7:0]  data
);

  logic [15:0] tci;
  assign tci = {VLAN_PCP, VLAN_DEI, vlan_id};

  // Byte select; bytes 12/13 carry either the TPID or the EtherType.
  always_comb begin
    data = 8'h00;
    case (idx)
      5'd0:  data = dest_mac[47:40];
      5'd1:  data = dest_mac[39:32];
      5'd2:  data = dest_mac[31:24];
      5'd3:  data = dest_mac[23:16];
      5'd4:  data = dest_mac[15:8];
      5'd5:  data = dest_mac[7:0];
      5'd6:  data = src_mac[47:40];
      5'd7:  data = src_mac[39:32];
      5'd8:  data = src_mac[31:24];
      5'd9:  data = src_mac[23:16];
      5'd10: data = src_mac[15:8];
      5'd11: data = src_mac[7:0];
      5'd12: data = vlan_present ? ETH_TPID_VLAN[15:8] : ethertype[15:8];
      5'd13: data = vlan_present ? ETH_TPID_VLAN[7:0]  : ethertype[7:0];
      5'd14: data = vlan_present ? tci[15:8]           : 8'h00;
      5'd15: data = vlan_present ? tci[7:0]            : 8'h00;
      5'd16: data = vlan_present ? ethertype[15:8]     : 8'h00;
      5'd17: data = vlan_present ? ethertype[7:0]      : 8'h00;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/eth_header_builder.sv
// TX L2 header serialiser: latches one metadata descriptor and emits DA/SA/[VLAN]/EtherType bytes.
module eth_header_builder
  import eth_parser_pkg::*;
#(
  parameter logic [2:0] VLAN_PCP = 3'd0,
  parameter logic       VLAN_DEI = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  eth_header_builder_if.slave bus
);

  tx_hdr_state_t state_r, state_s;
  eth_metadata_t meta_r, meta_s;
  logic [4:0]    idx_r, idx_s;
  logic [7:0]    tx_data_r, tx_data_s, sel_byte_s;
  logic          tx_valid_r, tx_valid_s;
  logic          tx_sof_r, tx_sof_s;
  logic          tx_eof_r, tx_eof_s;
  logic          hdr_done_r, hdr_done_s;
  logic          len_mismatch_r, len_mismatch_s;
  logic          meta_ready_r;
  logic          accept_s;
  logic          tx_fire_s;

  assign accept_s  = bus.meta_valid && meta_ready_r;
  assign tx_fire_s = tx_valid_r && bus.tx_ready;

  // Outputs are computed for the next cycle so every port comes straight from a flop.
  eth_hdr_byte_sel #(
    .VLAN_PCP (VLAN_PCP),
    .VLAN_DEI (VLAN_DEI)
  ) u_byte_sel (
    .dest_mac     (meta_s.dest_mac),
    .src_mac      (meta_s.src_mac),
    .ethertype    (meta_s.ethertype),
    .vlan_present (meta_s.vlan_present),
    .vlan_id      (meta_s.vlan_id),
    .idx          (idx_s),
    .data         (sel_byte_s)
  );

  // Next-state, counter and next-output logic.
  always_comb begin
    state_s        = state_r;
    meta_s         = meta_r;
    idx_s          = idx_r;
    tx_valid_s     = 1'b0;
    len_mismatch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s        = SEND;
          meta_s         = bus.meta_in;
          idx_s          = 5'd0;
          tx_valid_s     = 1'b1;
          len_mismatch_s = (bus.meta_in.l2_header_len != hdr_len(bus.meta_in.vlan_present));
        end else begin
          idx_s = 5'd0;
        end
      end
      SEND: begin
        tx_valid_s = 1'b1;
        if (tx_fire_s && tx_eof_r) begin
          state_s    = DONE;
          idx_s      = 5'd0;
          tx_valid_s = 1'b0;
        end else if (tx_fire_s) begin
          idx_s = idx_r + 5'd1;
        end else begin
          idx_s = idx_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        idx_s   = 5'd0;
      end
    endcase
    hdr_done_s = (state_s == DONE);
    tx_data_s  = tx_valid_s ? sel_byte_s : 8'h00;
    tx_sof_s   = tx_valid_s && (idx_s == 5'd0);
    tx_eof_s   = tx_valid_s && (idx_s == (hdr_len(meta_s.vlan_present) - 5'd1));
  end

  // State, latched metadata and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      meta_r         <= '0;
      idx_r          <= 5'd0;
      tx_data_r      <= 8'h00;
      tx_valid_r     <= 1'b0;
      tx_sof_r       <= 1'b0;
      tx_eof_r       <= 1'b0;
      hdr_done_r     <= 1'b0;
      len_mismatch_r <= 1'b0;
      meta_ready_r   <= 1'b0;
    end else begin
      state_r        <= state_s;
      meta_r         <= meta_s;
      idx_r          <= idx_s;
      tx_data_r      <= tx_data_s;
      tx_valid_r     <= tx_valid_s;
      tx_sof_r       <= tx_sof_s;
      tx_eof_r       <= tx_eof_s;
      hdr_done_r     <= hdr_done_s;
      len_mismatch_r <= len_mismatch_s;
      meta_ready_r   <= (state_s == IDLE);
    end
  end

  assign bus.meta_ready   = meta_ready_r;
  assign bus.tx_data      = tx_data_r;
  assign bus.tx_valid     = tx_valid_r;
  assign bus.tx_sof       = tx_sof_r;
  assign bus.tx_eof       = tx_eof_r;
  assign bus.hdr_done     = hdr_done_r;
  assign bus.len_mismatch = len_mismatch_r;

endmodule

// File: tb/tb_eth_header_builder.sv
// Directed bench for eth_header_builder: untagged, tagged, stall, back-to-back, mismatch, mid-frame reset.
module tb_eth_header_builder;
  import eth_parser_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   hs;

  eth_header_builder_if bus ();

  eth_header_builder #(
    .VLAN_PCP (3'd0),
    .VLAN_DEI (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic eth_metadata_t mk(input logic [47:0] da, input logic [47:0] sa,
                                       input logic [15:0] et, input logic vp,
                                       input logic [11:0] vid, input logic [4:0] len);
    eth_metadata_t m;
    m.dest_mac      = da;
    m.src_mac       = sa;
    m.ethertype     = et;
    m.vlan_present  = vp;
    m.vlan_id       = vid;
    m.l2_header_len = len;
    return m;
  endfunction

  // Present a descriptor until accepted; afterwards either drop valid or keep it up with a new one.
  task automatic start(input eth_metadata_t m, input bit hold, input eth_metadata_t m_next);
    int  w;
    bit  got;
    got = 1'b0;
    for (w = 0; w < 50 && !got; w++) begin
      if (bus.meta_ready) got = 1'b1;
      else step();
    end
    chk("ready_wait", {31'd0, got}, 32'd1);
    bus.meta_in    = m;
    bus.meta_valid = 1'b1;
    step();
    if (hold) begin
      bus.meta_in = m_next;
    end else begin
      bus.meta_valid = 1'b0;
      bus.meta_in    = ~m;
    end
  endtask

  // Consume one header, stalling bytes lo..hi for ncyc cycles each; exp holds bytes left-aligned.
  task automatic recv(input logic [143:0] exp, input int len, input int lo, input int hi,
                      input int ncyc, output int nhs);
    int k;
    int st;
    bit done;
    k    = 0;
    st   = 0;
    done = 1'b0;
    nhs  = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (k >= lo && k <= hi && st < ncyc) begin
        bus.tx_ready = 1'b0;
        st++;
      end else begin
        bus.tx_ready = 1'b1;
      end
      chk("tx_valid", {31'd0, bus.tx_valid}, 32'd1);
      chk("tx_data", {24'd0, bus.tx_data}, {24'd0, exp[143 - 8*k -: 8]});
      chk("tx_sof", {31'd0, bus.tx_sof}, {31'd0, (k == 0)});
      chk("tx_eof", {31'd0, bus.tx_eof}, {31'd0, (k == len - 1)});
      chk("ready_in_send", {31'd0, bus.meta_ready}, 32'd0);
      if (c > 0) chk("mismatch_width", {31'd0, bus.len_mismatch}, 32'd0);
      if (bus.tx_ready && bus.tx_valid) begin
        nhs++;
        if (bus.tx_eof || k >= 17) done = 1'b1;
        k++;
        st = 0;
      end
      step();
    end
    chk("eof_seen", {31'd0, done}, 32'd1);
    chk("byte_count", nhs, len);
  endtask

  // DONE cycle carries hdr_done, then IDLE with ready and still no tx_valid.
  task automatic tail();
    chk("hdr_done", {31'd0, bus.hdr_done}, 32'd1);
    chk("gap1_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("done_ready", {31'd0, bus.meta_ready}, 32'd0);
    step();
    chk("hdr_done_end", {31'd0, bus.hdr_done}, 32'd0);
    chk("gap2_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("idle_ready", {31'd0, bus.meta_ready}, 32'd1);
  endtask

  eth_metadata_t m1, m2, m4b, m5, none;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    none  = '0;
    m1  = mk(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 12'h000, 5'd14);
    m2  = mk(48'h001122334455, 48'h66778899AABB, 16'h86DD, 1'b1, 12'h123, 5'd18);
    m4b = mk(48'h020304050607, 48'h08090A0B0C0D, 16'h0806, 1'b0, 12'h000, 5'd14);
    m5  = mk(48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b1, 12'h005, 5'd14);

    rst_n          = 1'b0;
    bus.meta_in    = '0;
    bus.meta_valid = 1'b0;
    bus.tx_ready   = 1'b0;
    repeat (3) step();
    chk("rst_ready", {31'd0, bus.meta_ready}, 32'd0);
    chk("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_sof", {31'd0, bus.tx_sof}, 32'd0);
    chk("rst_eof", {31'd0, bus.tx_eof}, 32'd0);
    chk("rst_done", {31'd0, bus.hdr_done}, 32'd0);
    chk("rst_mism", {31'd0, bus.len_mismatch}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, bus.meta_ready}, 32'd1);

    // 1: untagged
    bus.tx_ready = 1'b1;
    start(m1, 1'b0, none);
    chk("t1_mism", {31'd0, bus.len_mismatch}, 32'd0);
    recv({112'h001122334455_66778899AABB_0800, 32'h0}, 14, -1, -1, 0, hs);
    tail();

    // 2: tagged, PCP/DEI zero
    start(m2, 1'b0, none);
    chk("t2_mism", {31'd0, bus.len_mismatch}, 32'd0);
    recv(144'h001122334455_66778899AABB_8100_0123_86DD, 18, -1, -1, 0, hs);
    tail();

    // 3: backpressure on bytes 3..5
    start(m1, 1'b0, none);
    recv({112'h001122334455_66778899AABB_0800, 32'h0}, 14, 3, 5, 3, hs);
    chk("t3_handshakes", hs, 32'd14);
    tail();

    // 4: back-to-back with meta_valid held high
    start(m1, 1'b1, m4b);
    recv({112'h001122334455_66778899AABB_0800, 32'h0}, 14, -1, -1, 0, hs);
    tail();
    step();
    bus.meta_valid = 1'b0;
    bus.meta_in    = ~m4b;
    recv({112'h020304050607_08090A0B0C0D_0806, 32'h0}, 14, -1, -1, 0, hs);
    tail();

    // 5: declared length disagrees with the VLAN flag
    start(m5, 1'b0, none);
    chk("t5_mism", {31'd0, bus.len_mismatch}, 32'd1);
    recv(144'h001122334455_66778899AABB_8100_0005_0800, 18, -1, -1, 0, hs);
    tail();

    // 6: reset while byte 7 is on the bus
    start(m1, 1'b0, none);
    repeat (7) step();
    chk("t6_byte7", {24'd0, bus.tx_data}, 32'h77);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("t6_rst_data", {24'd0, bus.tx_data}, 32'd0);
    chk("t6_rst_eof", {31'd0, bus.tx_eof}, 32'd0);
    chk("t6_rst_ready", {31'd0, bus.meta_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ready", {31'd0, bus.meta_ready}, 32'd1);
    chk("t6_idle_valid", {31'd0, bus.tx_valid}, 32'd0);
    start(m1, 1'b0, none);
    recv({112'h001122334455_66778899AABB_0800, 32'h0}, 14, -1, -1, 0, hs);
    tail();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
